// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Direct-mapped, read-only cache in front of a fixed-latency main memory.
// There are `SETS lines. Each line holds a valid bit, a 3-bit tag and one
// 4-word block. One request is handled at a time: IDLE -> COMPARE ->
// (FETCH ->) RESPOND -> IDLE. Every output is a register that is updated
// on entry to the state that owns it.
//
// Optional feature: define CACHE_CTRL_STATS_EN to add the hit_count and
// miss_count lookup counters. The default build leaves them out.
//
// Handshake: a request is accepted at a rising edge where req_valid &&
// req_ready && !rst. req_ready is high only in IDLE. resp_valid is a
// one-cycle pulse (the RESPOND state). resp_data holds its value between
// pulses.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid          read request pending (held until accepted)
//   req_address[14:0]  word address: [14:12] tag, [11:2] index, [1:0] offset
//   req_ready          controller idle and able to accept
//   resp_valid         response pulse
//   resp_data          requested word
//   mem_address[14:0]  latched request address, driven to main memory
//   mem_hit            0 while refilling (memory presents the block)
//   mem_data1..4       block words at offsets 0..3 from main memory
//   hit_count,
//   miss_count         lookup counters (CACHE_CTRL_STATS_EN only)
// -----------------------------------------------------------------------------
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif
`ifndef SETS
`define SETS 1024
`endif

module cache_controller #(
  parameter int MEM_LATENCY = 4  // legal range 1..15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [14:0]             req_address,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [`WORD_LENGTH-1:0] resp_data,
  output logic [14:0]             mem_address,
  output logic                    mem_hit,
  input  logic [`WORD_LENGTH-1:0] mem_data1,
  input  logic [`WORD_LENGTH-1:0] mem_data2,
  input  logic [`WORD_LENGTH-1:0] mem_data3,
  input  logic [`WORD_LENGTH-1:0] mem_data4
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int W = `WORD_LENGTH;

  typedef enum logic [1:0] {IDLE, COMPARE, FETCH, RESPOND} state_t;

  state_t     state;
  logic [3:0] lat_cnt;

  // Line storage. Only the valid bits need a reset; the tag and data arrays
  // are meaningless until their valid bit is set.
  logic [`SETS-1:0] valid_bits;
  logic [2:0]       tag_mem  [`SETS];
  logic [4*W-1:0]   data_mem [`SETS];

  // mem_address doubles as the latched request address.
  logic [9:0] idx;
  logic [2:0] tag;
  logic [1:0] off;
  assign idx = mem_address[11:2];
  assign tag = mem_address[14:12];
  assign off = mem_address[1:0];

  logic           lookup_hit;
  logic [4*W-1:0] line;
  logic [W-1:0]   hit_word;
  logic [W-1:0]   fill_word;
  logic           fill_en;

  assign lookup_hit = valid_bits[idx] && (tag_mem[idx] == tag);
  assign line       = data_mem[idx];
  // The refill commits on the last FETCH cycle. A reset in that same cycle
  // aborts it, so no line is written.
  assign fill_en    = (state == FETCH) && (lat_cnt == 4'd0) && !rst;

  always_comb begin
    hit_word  = line[W-1:0];
    fill_word = mem_data1;
    case (off)
      2'd0: begin hit_word = line[W-1:0];       fill_word = mem_data1; end
      2'd1: begin hit_word = line[2*W-1:W];     fill_word = mem_data2; end
      2'd2: begin hit_word = line[3*W-1:2*W];   fill_word = mem_data3; end
      default: begin hit_word = line[4*W-1:3*W]; fill_word = mem_data4; end
    endcase
  end

  // Tag/data arrays: written only by a completed refill, which overwrites
  // the whole line (there is nothing to write back).
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= {mem_data4, mem_data3, mem_data2, mem_data1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid_bits  <= '0;
      lat_cnt     <= 4'd0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      mem_hit     <= 1'b1;
      mem_address <= 15'd0;
`ifdef CACHE_CTRL_STATS_EN
      hit_count   <= 32'd0;
      miss_count  <= 32'd0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            mem_address <= req_address;
            req_ready   <= 1'b0;
            state       <= COMPARE;
          end
        end
        COMPARE: begin
          if (lookup_hit) begin
            resp_valid <= 1'b1;
            resp_data  <= hit_word;
            state      <= RESPOND;
`ifdef CACHE_CTRL_STATS_EN
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
`endif
          end else begin
            // The counter runs MEM_LATENCY-1 .. 0, so FETCH lasts
            // MEM_LATENCY cycles with mem_hit low.
            lat_cnt <= 4'(MEM_LATENCY - 1);
            mem_hit <= 1'b0;
            state   <= FETCH;
`ifdef CACHE_CTRL_STATS_EN
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
`endif
          end
        end
        FETCH: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            valid_bits[idx] <= 1'b1;
            mem_hit         <= 1'b1;
            resp_valid      <= 1'b1;
            resp_data       <= fill_word;  // forwarded straight from memory
            state           <= RESPOND;
          end
        end
        RESPOND: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          mem_hit   <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter: MEM_LATENCY, default 4, number of cycles mem_hit is held low per refill; legal range 1..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  input  1  requester has a read pending; held until accepted.
REQ-005 Port: req_address  input  15  word address; [14:12] tag, [11:2] index, [1:0] word offset.
REQ-006 Port: req_ready  output  1  controller can accept; acceptance = req_valid && req_ready at a rising edge.
REQ-007 Port: resp_valid  output  1  one-cycle pulse, resp_data valid.
REQ-008 Port: resp_data  output  `WORD_LENGTH  requested word.
REQ-009 Port: mem_address  output  15  address to main memory.
REQ-010 Port: mem_hit  output  1  drives main memory hit input; 0 = memory outputs block.
REQ-011 Port: mem_data1..mem_data4  input  `WORD_LENGTH each  block words at offsets 0..3.
REQ-012 Port (STATS only): hit_count, miss_count  output  32 each  lookup counters.

Function
REQ-013 Direct-mapped, `SETS (1024) lines, one 4-word block per line; per line: valid bit, 3-bit tag, 4 data words, all internal.
REQ-014 FSM states: IDLE, COMPARE, FETCH, RESPOND; registered outputs decoded from state.
REQ-015 IDLE: req_ready=1; on acceptance latch req_address, go COMPARE; otherwise stay.
REQ-016 COMPARE: valid[index] && tag match -> RESPOND (hit); else load latency counter with MEM_LATENCY-1, go FETCH (miss).
REQ-017 FETCH: mem_hit=0, mem_address=latched address; counter nonzero -> decrement; counter zero -> write mem_data1..4 into line, set tag, set valid, go RESPOND.
REQ-018 RESPOND: resp_valid=1, resp_data=line word selected by latched offset; next state IDLE unconditionally.
REQ-019 Latency from acceptance edge A: hit -> resp_valid high A+1..A+2; miss -> resp_valid high A+1+MEM_LATENCY..A+2+MEM_LATENCY.
REQ-020 Outside FETCH: mem_hit=1, mem_address holds last latched address; req_ready=0 in COMPARE, FETCH, RESPOND.
REQ-021 req_valid while req_ready=0 has no effect; req_address changes outside acceptance edges are ignored.
REQ-022 Max throughput one hit per 3 cycles; no request overlap or queuing.
REQ-023 Refill overwrites line unconditionally (no write-back; read-only cache).
REQ-024 resp_data holds last value when resp_valid=0.

Reset
REQ-025 rst=1 at edge: state IDLE, all valid bits 0, counter 0, req_ready=1, resp_valid=0, resp_data=0, mem_hit=1, mem_address=0.
REQ-026 rst in any state, incl. mid-FETCH, aborts operation; no line written, no resp_valid pulse.
REQ-027 rst has priority over acceptance in same cycle; request is dropped.

Configuration
REQ-028 Macro CACHE_CTRL_STATS_EN defined: hit_count/miss_count ports present, each incremented by 1 on COMPARE hit/miss resp., saturating at 32'hFFFFFFFF, cleared to 0 by rst.
REQ-029 Macro undefined: stats ports and counters absent; all other behaviour identical.

Verification (bench memory model returns word = word address; MEM_LATENCY=4)
REQ-030 After reset, read 0x0005 -> miss: mem_hit low exactly 4 cycles with mem_address=0x0005, resp_valid at A+5, resp_data=5.
REQ-031 Then read 0x0006 -> hit: mem_hit stays 1, resp_valid at A+1, resp_data=6.
REQ-032 Read 0x1005 (same index, tag 1) -> miss, resp_data=0x1005; then 0x0005 -> miss again, resp_data=5.
REQ-033 Start miss to 0x0020, assert rst in 2nd FETCH cycle -> next cycle IDLE, mem_hit=1, no resp_valid; re-read 0x0020 misses.
REQ-034 With CACHE_CTRL_STATS_EN: sequence 0x0005,0x0006,0x1005,0x0005,0x0007 -> hit_count=2, miss_count=3; rst -> both 0.
REQ-035 req_valid held high continuously with 3 hit addresses -> accepts exactly every 3 cycles, one resp_valid per request, in order.
